bcd_countdown_7: RTL and testbench

- Two-digit BCD down-counter, the countdown counterpart to the team's BCD up-counter.
- Latches a 7-bit binary start value when `run` rises, converts it to BCD with an iterative shift-add-3 converter, then decrements once per clock to 00 and flags `done`.
- Drives the same two-digit display path as the up-counter: `digit_1` = ones, `digit_2` = tens.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 47 ++++
 rtl/bcd_countdown_7.sv | 161 ++++++++++++++++
 tb/tb_bcd_countdown_7.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD counter family.
// Used by bcd_countdown_7 and bin2bcd_seq.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_MAX = 99;
  localparam int DIGIT_W = 4;

  typedef struct packed {
    logic               borrow;
    logic [DIGIT_W-1:0] digit;
  } bcd_dec_t;

  // One BCD digit minus one; 0 wraps to 9 and raises borrow.
  function automatic bcd_dec_t bcd_digit_dec(input logic [DIGIT_W-1:0] d);
    bcd_dec_t r;
    if (d == '0) begin
      r.borrow = 1'b1;
      r.digit  = DIGIT_W'(9);
    end else begin
      r.borrow = 1'b0;
      r.digit  = d - DIGIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) binary to two-digit BCD converter.
// tens/ones show the value the pending step would produce, so a caller can capture the result on the final step edge.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 7
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clear,
  input  logic               step,
  input  logic [BIN_W-1:0]   bin_in,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  logic [DIGIT_W-1:0]         r_tens;
  logic [DIGIT_W-1:0]         r_ones;
  logic [BIN_W-1:0]           r_bin;
  logic [DIGIT_W-1:0]         w_adj_tens;
  logic [DIGIT_W-1:0]         w_adj_ones;
  logic [2*DIGIT_W+BIN_W-1:0] w_shift;

  assign w_adj_tens = (r_tens >= DIGIT_W'(5)) ? r_tens + DIGIT_W'(3) : r_tens;
  assign w_adj_ones = (r_ones >= DIGIT_W'(5)) ? r_ones + DIGIT_W'(3) : r_ones;

  // Input is clamped upstream to 99, so no hundreds digit is ever shifted out of tens.
  assign w_shift = {w_adj_tens, w_adj_ones, r_bin} << 1;

  assign tens = w_shift[2*DIGIT_W+BIN_W-1 -: DIGIT_W];
  assign ones = w_shift[DIGIT_W+BIN_W-1 -: DIGIT_W];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tens <= '0;
      r_ones <= '0;
      r_bin  <= '0;
    end else if (clear) begin
      r_tens <= '0;
      r_ones <= '0;
      r_bin  <= bin_in;
    end else if (step) begin
      {r_tens, r_ones, r_bin} <= w_shift;
    end
  end

endmodule

// File: rtl/bcd_countdown_7.sv
// Two-digit BCD countdown: latch start on run rise, convert to BCD, decrement to 00 and flag done.
// Optional macro BCD_COUNTDOWN_RELOAD_EN: reload the converted start at 00 and keep counting.
//
// state | meaning
// IDLE  | waiting for a run rise; digits hold last value
// CONV  | CONV_CYCLES shift-add-3 steps; digits unchanged
// COUNT | one BCD decrement per clock
// DONE  | reached 00; hold until run drops
module bcd_countdown_7
  import bcd_pkg::*;
#(
  parameter int CONV_CYCLES = 7,
  parameter int BCD_MAX     = 99
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [CONV_CYCLES-1:0] start_count,
  input  logic                   run,
  output logic [DIGIT_W-1:0]     digit_1,
  output logic [DIGIT_W-1:0]     digit_2,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(CONV_CYCLES);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_run_q;
  logic [CNT_W-1:0]       r_conv_cnt;
  logic [DIGIT_W-1:0]     r_digit_1;
  logic [DIGIT_W-1:0]     r_digit_2;

  logic                   w_rise;
  logic                   w_conv_last;
  logic                   w_conv_clear;
  logic                   w_conv_step;
  logic                   w_conv_zero;
  logic [CONV_CYCLES-1:0] w_start_clamped;
  logic [DIGIT_W-1:0]     w_conv_tens;
  logic [DIGIT_W-1:0]     w_conv_ones;
  bcd_dec_t               w_dec_ones;
  bcd_dec_t               w_dec_tens;
  logic [DIGIT_W-1:0]     w_next_ones;
  logic [DIGIT_W-1:0]     w_next_tens;
  logic                   w_digits_zero;
  logic                   w_next_zero;

`ifdef BCD_COUNTDOWN_RELOAD_EN
  logic [2*DIGIT_W-1:0]   r_reload;
`endif

  assign w_rise          = run & ~r_run_q;
  assign w_conv_last     = (r_conv_cnt == '0);
  assign w_conv_clear    = run && (r_state == IDLE) && w_rise;
  assign w_conv_step     = run && (r_state == CONV);
  assign w_conv_zero     = (w_conv_tens == '0) && (w_conv_ones == '0);
  assign w_start_clamped = (start_count > CONV_CYCLES'(BCD_MAX)) ? CONV_CYCLES'(BCD_MAX)
                                                                : start_count;

  bin2bcd_seq #(
    .BIN_W (CONV_CYCLES)
  ) u_bin2bcd (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (w_conv_clear),
    .step   (w_conv_step),
    .bin_in (w_start_clamped),
    .tens   (w_conv_tens),
    .ones   (w_conv_ones)
  );

  // Both digits borrowing means the display currently reads 00.
  assign w_dec_ones    = bcd_digit_dec(r_digit_1);
  assign w_dec_tens    = bcd_digit_dec(r_digit_2);
  assign w_digits_zero = w_dec_ones.borrow & w_dec_tens.borrow;
  assign w_next_ones   = w_dec_ones.digit;
  assign w_next_tens   = w_dec_ones.borrow ? w_dec_tens.digit : r_digit_2;
  assign w_next_zero   = (w_next_tens == '0) && (w_next_ones == '0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!run) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_rise) w_state_next = CONV;
        CONV:  if (w_conv_last) w_state_next = w_conv_zero ? DONE : COUNT;
`ifdef BCD_COUNTDOWN_RELOAD_EN
        COUNT: w_state_next = COUNT;
`else
        COUNT: if (w_next_zero) w_state_next = DONE;
`endif
        DONE:  w_state_next = DONE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_run_q    <= 1'b0;
      r_conv_cnt <= '0;
      r_digit_1  <= '0;
      r_digit_2  <= '0;
`ifdef BCD_COUNTDOWN_RELOAD_EN
      r_reload   <= '0;
`endif
    end else begin
      r_run_q <= run;
      // A low run aborts: nothing below moves, so the digits freeze.
      if (run) begin
        case (r_state)
          IDLE: begin
            if (w_rise) r_conv_cnt <= CNT_W'(CONV_CYCLES - 1);
          end
          CONV: begin
            if (w_conv_last) begin
              r_digit_2 <= w_conv_tens;
              r_digit_1 <= w_conv_ones;
`ifdef BCD_COUNTDOWN_RELOAD_EN
              r_reload  <= {w_conv_tens, w_conv_ones};
`endif
            end else begin
              r_conv_cnt <= r_conv_cnt - CNT_W'(1);
            end
          end
          COUNT: begin
            if (w_digits_zero) begin
`ifdef BCD_COUNTDOWN_RELOAD_EN
              {r_digit_2, r_digit_1} <= r_reload;
`endif
            end else begin
              r_digit_1 <= w_next_ones;
              r_digit_2 <= w_next_tens;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign digit_1 = r_digit_1;
  assign digit_2 = r_digit_2;
  assign busy    = (r_state == CONV) || (r_state == COUNT);
`ifdef BCD_COUNTDOWN_RELOAD_EN
  assign done    = (r_state == DONE) || ((r_state == COUNT) && w_digits_zero);
`else
  assign done    = (r_state == DONE);
`endif

endmodule

// File: tb/tb_bcd_countdown_7.sv
// Scoreboard bench for bcd_countdown_7: a decimal reference model queues the expected outputs for every edge,
// and a negedge monitor pops and compares them.
module tb_bcd_countdown_7;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] start_count;
  logic       run;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  bcd_countdown_7 dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start_count (start_count),
    .run         (run),
    .digit_1     (digit_1),
    .digit_2     (digit_2),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  // Reference model in decimal terms: remaining conversion edges, counting flag, displayed value.
  bit m_run_q     = 1'b0;
  int m_conv_left = 0;
  bit m_counting  = 1'b0;
  bit m_done      = 1'b0;
  int m_value     = 0;
  int m_pending   = 0;
  int m_reload    = 0;

  task automatic model_edge(input bit rst_n, input bit r, input int s);
    bit rise;
    if (!rst_n) begin
      m_run_q = 0; m_conv_left = 0; m_counting = 0; m_done = 0; m_value = 0;
      m_reload = 0;
    end else begin
      rise = r && !m_run_q;
      if (!r) begin
        m_conv_left = 0; m_counting = 0; m_done = 0;
      end else if (m_conv_left > 0) begin
        m_conv_left--;
        if (m_conv_left == 0) begin
          m_value  = m_pending;
          m_reload = m_pending;
          if (m_pending == 0) m_done = 1; else m_counting = 1;
        end
      end else if (m_counting) begin
`ifdef BCD_COUNTDOWN_RELOAD_EN
        if (m_value == 0) m_value = m_reload; else m_value--;
`else
        m_value--;
        if (m_value == 0) begin
          m_counting = 0; m_done = 1;
        end
`endif
      end else if (!m_done && rise) begin
        m_pending   = (s > 99) ? 99 : s;
        m_conv_left = 7;
      end
      m_run_q = r;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.d2   = 4'(m_value / 10);
    e.d1   = 4'(m_value % 10);
    e.busy = (m_conv_left > 0) || m_counting;
`ifdef BCD_COUNTDOWN_RELOAD_EN
    e.done = m_done || (m_counting && m_value == 0);
`else
    e.done = m_done;
`endif
    return e;
  endfunction

  task automatic tick(input bit rst_n, input bit r, input int s);
    RST_N       = rst_n;
    run         = r;
    start_count = 7'(s & 127);
    model_edge(rst_n, r, s & 127);
    exp_q.push_back(model_out());
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n, input bit r, input int s);
    for (int i = 0; i < n; i++) tick(1'b1, r, s);
  endtask

  task automatic check_state(input logic [3:0] d2, input logic [3:0] d1, input logic b,
                             input logic d, input string tag);
    n_checks++;
    if ({digit_2, digit_1, busy, done} !== {d2, d1, b, d}) begin
      n_fail++;
      $display("FAIL %s: got d2=%0d d1=%0d busy=%b done=%b, expected d2=%0d d1=%0d busy=%b done=%b",
               tag, digit_2, digit_1, busy, done, d2, d1, b, d);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      n_checks++;
      if ({digit_2, digit_1, busy, done} !== e_mon) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got d2=%0d d1=%0d busy=%b done=%b, expected d2=%0d d1=%0d busy=%b done=%b",
                 cyc, digit_2, digit_1, busy, done, e_mon.d2, e_mon.d1, e_mon.busy, e_mon.done);
      end
    end
  end

  int s;
  int len;

  initial begin
    RST_N = 1'b0; run = 1'b0; start_count = '0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0);
    check_state(4'd0, 4'd0, 1'b0, 1'b0, "reset state");
    ticks(2, 1'b0, 0);

    // 73: conversion then 73 decrements to done
    ticks(1 + 7 + 73 + 3, 1'b1, 73);
    check_state(4'd0, 4'd0, 1'b0, 1'b1, "expired countdown from 73");
    ticks(2, 1'b0, 73);

    // 15 with start_count changed mid-count
    ticks(12, 1'b1, 15);
    ticks(15, 1'b1, 40);
    ticks(2, 1'b0, 40);

    // over-range start clamps to 99
    ticks(1 + 7 + 99 + 2, 1'b1, 118);
    ticks(2, 1'b0, 118);

    // abort at 42, then restart from 5
    ticks(1 + 7 + 18, 1'b1, 60);
    ticks(3, 1'b0, 60);
    check_state(4'd4, 4'd2, 1'b0, 1'b0, "abort freeze at 42");
    ticks(1 + 7 + 5 + 3, 1'b1, 5);
    ticks(2, 1'b0, 5);

    // start of zero
    ticks(1 + 7 + 3, 1'b1, 0);
    ticks(2, 1'b0, 0);

    // small start, exercises reload when enabled
    ticks(1 + 7 + 12, 1'b1, 3);
    ticks(2, 1'b0, 3);

    // reset while running has priority
    ticks(20, 1'b1, 50);
    tick(1'b0, 1'b1, 50);
    ticks(12, 1'b1, 50);
    ticks(2, 1'b0, 50);

    for (int it = 0; it < 40; it++) begin
      s   = int'($urandom_range(0, 127));
      len = int'($urandom_range(1, 120));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) tick(1'b1, 1'b1, int'($urandom_range(0, 127)));
        else tick(1'b1, 1'b1, s);
      end
      ticks(int'($urandom_range(1, 3)), 1'b0, s);
      if ($urandom_range(0, 9) == 0) tick(1'b0, 1'($urandom_range(0, 1)), s);
    end

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
